reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 95 +++++++++
 tb/tb_reg_file_sb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with two read ports, two write ports (port 4 wins) and a busy-bit
// scoreboard that tracks issued-but-not-written-back destination registers.
module reg_file_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            BUSY1,
  output logic            BUSY2,
  input  logic            WE3,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE4,
  input  logic [AW-1:0]   A4,
  input  logic [XLEN-1:0] WD4,
  input  logic            ISS,
  input  logic [AW-1:0]   ISS_RD,
  output logic            STALL,
  output logic [AW:0]     BUSY_CNT
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] wr_mask, eff_busy;
  logic [AW:0]     cnt_q, cnt_d;
  logic            wr3, wr4, bypass_on, accept;

  assign wr3       = WE3 && (A3 != '0);
  assign wr4       = WE4 && (A4 != '0);
  // Forwarding is suppressed while reset is held so readers see stored state.
  assign bypass_on = (BYPASS != 0) && rst;

  always_comb begin
    wr_mask = '0;
    if (wr3) wr_mask[A3] = 1'b1;
    if (wr4) wr_mask[A4] = 1'b1;
  end

  assign eff_busy = bypass_on ? (busy_q & ~wr_mask) : busy_q;

  always_comb begin
    RD1 = regs_q[A1];
    if (bypass_on && wr3 && (A3 == A1)) RD1 = WD3;
    if (bypass_on && wr4 && (A4 == A1)) RD1 = WD4;
    if (A1 == '0) RD1 = '0;
  end

  always_comb begin
    RD2 = regs_q[A2];
    if (bypass_on && wr3 && (A3 == A2)) RD2 = WD3;
    if (bypass_on && wr4 && (A4 == A2)) RD2 = WD4;
    if (A2 == '0) RD2 = '0;
  end

  assign BUSY1  = (A1 != '0) && eff_busy[A1];
  assign BUSY2  = (A2 != '0) && eff_busy[A2];
  assign STALL  = rst && ISS && (BUSY1 || BUSY2 || ((ISS_RD != '0) && eff_busy[ISS_RD]));
  assign accept = rst && ISS && !STALL && (ISS_RD != '0);

  // Set is applied after clear so a same-cycle issue keeps the register busy.
  always_comb begin
    busy_d = busy_q & ~wr_mask;
    if (accept) busy_d[ISS_RD] = 1'b1;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr3) regs_q[A3] <= WD3;
      if (wr4) regs_q[A4] <= WD4;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign BUSY_CNT = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, a forwarding-off sequence, then random
// traffic compared against an array-based model of both BYPASS=1 and BYPASS=0 builds.
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   a1, a2, a3, a4, iss_rd;
  logic [XLEN-1:0] wd3, wd4;
  logic            we3, we4, iss;

  logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic            busy1_b, busy2_b, stall_b, busy1_n, busy2_n, stall_n;
  logic [AW:0]     cnt_b, cnt_n;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(rd1_b), .RD2(rd2_b),
    .BUSY1(busy1_b), .BUSY2(busy2_b), .WE3(we3), .A3(a3), .WD3(wd3),
    .WE4(we4), .A4(a4), .WD4(wd4), .ISS(iss), .ISS_RD(iss_rd),
    .STALL(stall_b), .BUSY_CNT(cnt_b)
  );

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(rd1_n), .RD2(rd2_n),
    .BUSY1(busy1_n), .BUSY2(busy2_n), .WE3(we3), .A3(a3), .WD3(wd3),
    .WE4(we4), .A4(a4), .WD4(wd4), .ISS(iss), .ISS_RD(iss_rd),
    .STALL(stall_n), .BUSY_CNT(cnt_n)
  );

  // Reference state: storage is common to both builds, busy bits are per build
  // (index 0 = forwarding on, 1 = forwarding off).
  logic [XLEN-1:0] mreg [NREG];
  bit              mbusy [2][NREG];

  typedef struct {
    logic            rst, we3, we4, iss;
    logic [AW-1:0]   a3, a4, iss_rd, a1;
    logic [XLEN-1:0] wd3, wd4;
    logic [XLEN-1:0] e_rd1;
    logic            e_busy1, e_stall;
    logic [AW:0]     e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic w3, logic [AW-1:0] ad3, logic [XLEN-1:0] d3,
                              logic w4, logic [AW-1:0] ad4, logic [XLEN-1:0] d4,
                              logic is, logic [AW-1:0] ird, logic [AW-1:0] ad1,
                              logic [XLEN-1:0] erd, logic eb, logic es, logic [AW:0] ec);
    vec_t v;
    v.rst = r; v.we3 = w3; v.a3 = ad3; v.wd3 = d3; v.we4 = w4; v.a4 = ad4; v.wd4 = d4;
    v.iss = is; v.iss_rd = ird; v.a1 = ad1;
    v.e_rd1 = erd; v.e_busy1 = eb; v.e_stall = es; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(logic [AW-1:0] a);
    return (a != 0) && ((we3 && a3 == a) || (we4 && a4 == a));
  endfunction

  function automatic logic [XLEN-1:0] m_rd(int b, logic [AW-1:0] a);
    if (a == 0) return '0;
    if (b == 0 && rst) begin
      if (we4 && a4 == a) return wd4;
      if (we3 && a3 == a) return wd3;
    end
    return mreg[a];
  endfunction

  function automatic bit m_busy(int b, logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (b == 0 && rst && hit(a)) return 1'b0;
    return mbusy[b][a];
  endfunction

  function automatic bit m_stall(int b);
    return rst && iss && (m_busy(b, a1) || m_busy(b, a2) || m_busy(b, iss_rd));
  endfunction

  function automatic int m_cnt(int b);
    int c = 0;
    for (int i = 0; i < NREG; i++) if (mbusy[b][i]) c++;
    return c;
  endfunction

  task automatic check_model();
    chk("rd1_byp",   rd1_b,   m_rd(0, a1));
    chk("rd2_byp",   rd2_b,   m_rd(0, a2));
    chk("busy1_byp", 32'(busy1_b), 32'(m_busy(0, a1)));
    chk("busy2_byp", 32'(busy2_b), 32'(m_busy(0, a2)));
    chk("stall_byp", 32'(stall_b), 32'(m_stall(0)));
    chk("cnt_byp",   32'(cnt_b),   m_cnt(0));
    chk("rd1_nob",   rd1_n,   m_rd(1, a1));
    chk("rd2_nob",   rd2_n,   m_rd(1, a2));
    chk("busy1_nob", 32'(busy1_n), 32'(m_busy(1, a1)));
    chk("busy2_nob", 32'(busy2_n), 32'(m_busy(1, a2)));
    chk("stall_nob", 32'(stall_n), 32'(m_stall(1)));
    chk("cnt_nob",   32'(cnt_n),   m_cnt(1));
  endtask

  // Advance through the rising edge and apply the same edge to the model.
  task automatic commit();
    bit acc [2];
    for (int b = 0; b < 2; b++) acc[b] = rst && iss && (iss_rd != 0) && !m_stall(b);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mreg[i] = '0;
        mbusy[0][i] = 1'b0;
        mbusy[1][i] = 1'b0;
      end
    end else begin
      if (we3 && a3 != 0) mreg[a3] = wd3;
      if (we4 && a4 != 0) mreg[a4] = wd4;
      for (int b = 0; b < 2; b++) begin
        if (we3 && a3 != 0) mbusy[b][a3] = 1'b0;
        if (we4 && a4 != 0) mbusy[b][a4] = 1'b0;
        if (acc[b]) mbusy[b][iss_rd] = 1'b1;
      end
    end
  endtask

  task automatic idle_inputs();
    we3 = 0; we4 = 0; iss = 0; a1 = 0; a2 = 0; a3 = 0; a4 = 0; iss_rd = 0;
    wd3 = '0; wd4 = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    for (int i = 0; i < NREG; i++) begin
      mreg[i] = '0;
      mbusy[0][i] = 1'b0;
      mbusy[1][i] = 1'b0;
    end

    //           rst we3 a3 wd3           we4 a4 wd4           iss ird a1 rd1       b1 st cnt
    tbl.push_back(mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0,  5, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 5, 32'h1,        1, 6,  5, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,            0, 0,  5, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 1, 7, 32'h11,       1, 7, 32'h22,       0, 0,  7, 32'h22,       0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,            0, 0,  7, 32'h22,       0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            1, 0, 32'hFFFFFFFF, 1, 0,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,            0, 0,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,            1, 3,  0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,            1, 10, 3, 32'h0,        1, 1, 1));
    tbl.push_back(mk(1, 1, 3, 32'h33,       0, 0, 0,            0, 0,  3, 32'h33,       0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,            0, 0,  3, 32'h33,       0, 0, 0));
    tbl.push_back(mk(1, 1, 9, 32'h99,       0, 0, 0,            1, 9,  9, 32'h99,       0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,            0, 0,  9, 32'h99,       1, 0, 1));
    tbl.push_back(mk(0, 1, 12, 32'h5,       0, 0, 0,            1, 12, 9, 32'h99,       1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,            0, 0,  9, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,            1, 9,  9, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 1, 9, 32'h42,       0, 0, 0,            1, 9,  9, 32'h42,       0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,            0, 0,  9, 32'h42,       1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,            1, 9, 32'h7,        0, 0,  9, 32'h7,        0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,            0, 0,  9, 32'h7,        0, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      idle_inputs();
      rst = tbl[i].rst; we3 = tbl[i].we3; a3 = tbl[i].a3; wd3 = tbl[i].wd3;
      we4 = tbl[i].we4; a4 = tbl[i].a4; wd4 = tbl[i].wd4;
      iss = tbl[i].iss; iss_rd = tbl[i].iss_rd; a1 = tbl[i].a1;
      #1;
      chk($sformatf("tbl%0d_rd1", i),   rd1_b,         tbl[i].e_rd1);
      chk($sformatf("tbl%0d_busy1", i), 32'(busy1_b),  32'(tbl[i].e_busy1));
      chk($sformatf("tbl%0d_stall", i), 32'(stall_b),  32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_cnt", i),   32'(cnt_b),    32'(tbl[i].e_cnt));
      check_model();
      commit();
    end

    // Forwarding-off build: new data shows up only after the edge.
    @(negedge clk);
    idle_inputs();
    rst = 1; we3 = 1; a3 = 4; wd3 = 32'h55; a1 = 4;
    #1;
    chk("nob_same_cycle_old", rd1_n, 32'h0);
    chk("byp_same_cycle_new", rd1_b, 32'h55);
    check_model();
    commit();
    @(negedge clk);
    idle_inputs();
    a1 = 4;
    #1;
    chk("nob_next_cycle_new", rd1_n, 32'h55);
    check_model();
    commit();

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 59) != 0);
      we3    = ($urandom_range(0, 2) == 0);
      we4    = ($urandom_range(0, 3) == 0);
      iss    = ($urandom_range(0, 4) < 3);
      a1     = AW'($urandom_range(0, NREG - 1));
      a2     = AW'($urandom_range(0, NREG - 1));
      a3     = AW'($urandom_range(0, NREG - 1));
      a4     = ($urandom_range(0, 4) == 0) ? a3 : AW'($urandom_range(0, NREG - 1));
      iss_rd = AW'($urandom_range(0, NREG - 1));
      wd3    = $urandom;
      wd4    = $urandom;
      #1;
      check_model();
      commit();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
